debugger_rx: RTL and testbench
==============================

# debugger_rx

Command receiver for the MIPS debug link. It consumes bytes from the UART receiver and decodes single-byte debugger commands: run, step, pipeline reset and program load. It drives the processor's enable/reset, writes loaded words into instruction memory, and triggers the frame transmitter (`sendSignal`/`dataSent` handshake) after run or step completes. It sits between the UART RX core and the MIPS top level, paired with the debugger transmitter.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; max load = 2^ADDR_W − 1 words.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx_done_tick`  in  1  one-cycle pulse: `r_data` holds a new received byte.
- `r_data`  in  8  received byte.
- `halt`  in  1  processor has retired HALT; level.
- `data_sent`  in  1  transmitter idle flag; high = idle, low = frame in flight.
- `mips_en`  out  1  processor clock-enable.
- `mips_rst`  out  1  one-cycle synchronous processor reset pulse.
- `send_signal`  out  1  one-cycle pulse requesting a debug-frame transmission.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word written.
- `cmd_error`  out  1  one-cycle pulse on an unknown command byte.
- `busy`  out  1  high in any state other than IDLE.
- `state`  out  3  current state encoding, for debug.

## Operation
- All outputs are registered. On reset, every output is 0, state is IDLE, and all counters and the shift register are cleared.
- Commands are accepted only in IDLE. The command byte is sampled on `rx_done_tick`.
  - `'c'` (0x63) → RUN.
  - `'s'` (0x73) → STEP.
  - `'r'` (0x72) → RST.
  - `'l'` (0x6C) → LOAD_CNT.
  - Any other byte → `cmd_error` pulse; stay in IDLE.
- RUN: `mips_en`=1 every cycle. When `halt` is sampled high, `mips_en`=0 from the next cycle, then → SEND.
- STEP: `mips_en`=1 for exactly one cycle, then → SEND.
- SEND: `send_signal`=1 for one cycle, then → WAIT_TX.
- WAIT_TX: wait for `data_sent` low and then high again. A flag tracks that the low was observed. On the return to high → IDLE.
- RST: `mips_rst`=1 for one cycle, then → IDLE. No frame is sent.
- LOAD_CNT: the next byte is word count N.
  - N=0 → IDLE with no writes.
  - Otherwise clear the word index and byte counter, then → LOAD_WORD.
- LOAD_WORD: each byte is shifted into a 32-bit register, big-endian (first byte lands in bits 31:24).
  - On the 4th byte: `imem_we`=1 for one cycle, `imem_addr`=word index, `imem_wdata`=assembled word. Then increment the word index and clear the byte counter.
  - After word N is written → IDLE.
- Bytes arriving in RUN, STEP, SEND, WAIT_TX or RST are discarded silently. They never raise `cmd_error`.
- The word index is ADDR_W bits wide and cannot wrap, because N ≤ 255 at ADDR_W=8. For ADDR_W<8, N is truncated to ADDR_W bits.

## Timing
- Command byte on cycle T (`rx_done_tick`) → state changes on T+1.
  - `'s'` on T: `mips_en` high on T+1 only; `send_signal` high on T+2.
  - `'r'` on T: `mips_rst` high on T+1.
- RUN: `halt` sampled high on cycle H → `mips_en` low on H+1, `send_signal` on H+2.
  - If `halt` is already high on entry, the processor still gets exactly one enable cycle.
- The 4th byte of a word arriving on cycle W → `imem_we`/`imem_addr`/`imem_wdata` valid on W+1. The return to IDLE after the last word also happens on W+1.
- A byte may arrive every cycle. Back-to-back `rx_done_tick` pulses are all absorbed.
- `data_sent` already low in the first WAIT_TX cycle counts as the observed low.
- Asynchronous reset in any state aborts the operation immediately.
  - Outputs go to 0 and state to IDLE.
  - A partially assembled word is discarded with no write.

## Structure
- Shared package `debugger_pkg` holds:
  - Command byte constants: `CMD_RUN`, `CMD_STEP`, `CMD_RST`, `CMD_LOAD`.
  - The 3-bit state encoding: IDLE, RUN, STEP, SEND, WAIT_TX, RST, LOAD_CNT, LOAD_WORD.
  - `FRAME_BITS`=1760, shared with the transmitter.
- One sub-module, `byte_word_packer`: 4-byte big-endian shift register plus 2-bit byte counter.
  - Inputs: `clr`, `byte_valid`, `byte`.
  - Outputs: `word`, `word_valid`.
- FSM, word index and `WAIT_TX` flag stay in the top module.

## Test plan
- Send 0x73 → exactly one `mips_en` cycle, `send_signal` one cycle later; drop `data_sent` for 10 cycles then raise it → `busy` falls; no `cmd_error`.
- Send 0x63, raise `halt` 50 cycles later → `mips_en` high exactly 50 cycles (first RUN cycle through the cycle `halt` is sampled), one `send_signal`, then IDLE after the `data_sent` low→high.
- Send 0x6C, 0x02, then 0x20,0x08,0x00,0x05, 0x00,0x00,0x00,0x0C → writes (addr 0, 0x20080005) then (addr 1, 0x0000000C); `imem_we` pulses exactly twice.
- Send 0x6C, 0x00 → no `imem_we`, IDLE; then 0x41 → `cmd_error` one cycle, state IDLE.
- Send 0x72 → `mips_rst` one cycle, no `send_signal`; a byte 0x73 arriving during WAIT_TX of a prior step is ignored (no second `mips_en`).
- Load of N=3 with reset asserted after the 6th data byte → all outputs 0 immediately; only addr 0 was written; a following 0x73 steps normally.

Source files
------------

// File: rtl/debugger_pkg.sv
// Shared definitions for the MIPS debug link: command bytes, receiver
// state encoding and the frame length agreed with the transmitter.
package debugger_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_RST  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_LOAD = 8'h6C;  // 'l'

  // Length of one debug frame, in bits, as produced by the transmitter.
  localparam int FRAME_BITS = 1760;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP      = 3'd2,
    SEND      = 3'd3,
    WAIT_TX   = 3'd4,
    RST       = 3'd5,
    LOAD_CNT  = 3'd6,
    LOAD_WORD = 3'd7
  } state_t;

  // True for the four bytes the receiver understands as commands.
  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_RUN) || (b == CMD_STEP) || (b == CMD_RST) || (b == CMD_LOAD);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles four received bytes into one big-endian 32-bit word.
// The first three bytes are held; the fourth is combined on the fly so the
// complete word is presented in the same cycle as that byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sr_q;
  logic [1:0]  cnt_q;
  logic [31:0] sr_d;

  // Shift the new byte in at the bottom so the first byte ends up on top.
  always_comb begin
    sr_d         = {sr_q, byte_i};
    word_o       = sr_d;
    word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  end

  // Byte counter and shift storage; the 2-bit counter wraps after each word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      sr_q  <= sr_d[23:0];
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/debugger_rx.sv
// Debug-link command receiver: decodes run/step/reset/load commands from
// the UART byte stream, drives the processor enable/reset, writes loaded
// words into instruction memory and kicks the frame transmitter.
module debugger_rx
  import debugger_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        r_data,
  input  logic              halt,
  input  logic              data_sent,
  output logic              mips_en,
  output logic              mips_rst,
  output logic              send_signal,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cmd_error,
  output logic              busy,
  output logic [2:0]        state
);

  state_t state_q, state_d;

  // halt_seen: halt observed in RUN; one idle-enable cycle follows before SEND.
  // low_seen: transmitter went busy (data_sent low) since the frame request.
  logic halt_seen_q, halt_seen_d;
  logic low_seen_q, low_seen_d;

  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] n_cnt;

  logic              mips_en_q, mips_en_d;
  logic              mips_rst_q, mips_rst_d;
  logic              send_q, send_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cmd_error_q, cmd_error_d;
  logic              busy_q, busy_d;

  logic        pk_clr;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        pk_word_valid;

  // Word count byte, truncated to the address width for narrow memories.
  assign n_cnt = ADDR_W'(r_data);

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (r_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // Next-state and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_d      = state_q;
    halt_seen_d  = halt_seen_q;
    low_seen_d   = low_seen_q;
    count_d      = count_q;
    widx_d       = widx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cmd_error_d  = 1'b0;
    pk_clr       = 1'b0;
    pk_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          case (r_data)
            CMD_RUN: begin
              state_d     = RUN;
              halt_seen_d = 1'b0;
            end
            CMD_STEP: state_d = STEP;
            CMD_RST:  state_d = RST;
            CMD_LOAD: state_d = LOAD_CNT;
            default:  cmd_error_d = 1'b1;
          endcase
        end
      end
      RUN: begin
        if (halt_seen_q) begin
          state_d     = SEND;
          halt_seen_d = 1'b0;
        end else if (halt) begin
          halt_seen_d = 1'b1;
        end
      end
      STEP: state_d = SEND;
      SEND: begin
        state_d    = WAIT_TX;
        low_seen_d = 1'b0;
      end
      WAIT_TX: begin
        if (!data_sent) begin
          low_seen_d = 1'b1;
        end else if (low_seen_q) begin
          state_d    = IDLE;
          low_seen_d = 1'b0;
        end
      end
      RST: state_d = IDLE;
      LOAD_CNT: begin
        if (rx_done_tick) begin
          count_d = n_cnt;
          if (n_cnt == '0) begin
            state_d = IDLE;
          end else begin
            widx_d  = '0;
            pk_clr  = 1'b1;
            state_d = LOAD_WORD;
          end
        end
      end
      LOAD_WORD: begin
        pk_valid = rx_done_tick;
        if (pk_word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = widx_q;
          imem_wdata_d = pk_word;
          widx_d       = widx_q + ADDR_W'(1);
          if ((widx_q + ADDR_W'(1)) == count_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mips_en_d  = ((state_d == RUN) && !halt_seen_d) || (state_d == STEP);
    mips_rst_d = (state_d == RST);
    send_d     = (state_d == SEND);
    busy_d     = (state_d != IDLE);
  end

  // State, bookkeeping and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      halt_seen_q  <= 1'b0;
      low_seen_q   <= 1'b0;
      count_q      <= '0;
      widx_q       <= '0;
      mips_en_q    <= 1'b0;
      mips_rst_q   <= 1'b0;
      send_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cmd_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_seen_q  <= halt_seen_d;
      low_seen_q   <= low_seen_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      mips_en_q    <= mips_en_d;
      mips_rst_q   <= mips_rst_d;
      send_q       <= send_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cmd_error_q  <= cmd_error_d;
      busy_q       <= busy_d;
    end
  end

  assign mips_en     = mips_en_q;
  assign mips_rst    = mips_rst_q;
  assign send_signal = send_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cmd_error   = cmd_error_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_debugger_rx.sv
// Bench for debugger_rx: first-cycle command table, hand-written timing
// sequences, and a randomized command stream checked against event totals.
module tb_debugger_rx;
  import debugger_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_done_tick = 1'b0;
  logic [7:0]        r_data = 8'h00;
  logic              halt = 1'b0;
  logic              data_sent = 1'b1;
  logic              mips_en, mips_rst, send_signal, imem_we, cmd_error, busy;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [2:0]        state;

  debugger_rx #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .halt(halt), .data_sent(data_sent), .mips_en(mips_en), .mips_rst(mips_rst),
    .send_signal(send_signal), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cmd_error(cmd_error), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Event monitor, sampled mid-cycle.
  int en_cnt = 0, send_cnt = 0, rst_cnt = 0, err_cnt = 0;
  logic [39:0] got_wr[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (mips_en)     en_cnt++;
      if (send_signal) send_cnt++;
      if (mips_rst)    rst_cnt++;
      if (cmd_error)   err_cnt++;
      if (imem_we)     got_wr.push_back({imem_addr, imem_wdata});
    end
  end

  int b_en, b_send, b_rst, b_err, b_wr;
  logic [39:0] exp_wr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = v;
    r_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic snap();
    b_en = en_cnt; b_send = send_cnt; b_rst = rst_cnt; b_err = err_cnt;
    b_wr = got_wr.size();
    exp_wr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_done_tick = 1'b0; r_data = 8'h00; halt = 1'b0; data_sent = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {mips_en, mips_rst, send_signal, imem_we, cmd_error, busy,
                          state, imem_addr, imem_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input state_t tgt, input string name);
    int n = 0;
    while (state !== tgt && n < 50) begin
      tick(1'b0, 8'h00);
      n++;
    end
    chk(name, state, tgt);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick(1'b0, 8'h00);
      n++;
    end
    chk(name, {busy, state}, 4'd0);
  endtask

  // Let the transmitter go busy for low_len cycles, then idle again.
  // mode 0: quiet line, 1: 's' every cycle, 2: random junk bytes.
  task automatic finish_frame(input int low_len, input int mode, input string name);
    wait_state(WAIT_TX, {name, "_enter_wait"});
    data_sent = 1'b0;
    for (int i = 1; i < low_len; i++) begin
      if (mode == 1)      tick(1'b1, CMD_STEP);
      else if (mode == 2) tick(1'($urandom_range(0, 1)), 8'($urandom));
      else                tick(1'b0, 8'h00);
    end
    tick(1'b0, 8'h00);
    chk({name, "_held"}, state, WAIT_TX);
    data_sent = 1'b1;
    wait_idle({name, "_idle"});
  endtask

  task automatic do_step(input string name);
    tick(1'b1, CMD_STEP);
    tick(1'b0, 8'h00);
    chk({name, "_t1"}, {mips_en, send_signal, state}, {1'b1, 1'b0, 3'(STEP)});
    tick(1'b0, 8'h00);
    chk({name, "_t2"}, {mips_en, send_signal}, 2'b01);
  endtask

  // k cycles of running before halt is raised: k+1 enable cycles expected.
  task automatic do_run(input int k, input logic junk, input string name);
    tick(1'b1, CMD_RUN);
    for (int i = 0; i < k; i++) tick(junk & 1'($urandom_range(0, 1)), 8'($urandom));
    tick(1'b0, 8'h00);
    halt = 1'b1;
    chk({name, "_en_at_halt"}, mips_en, 1'b1);
    tick(1'b0, 8'h00);
    chk({name, "_h1"}, {mips_en, send_signal}, 2'b00);
    tick(1'b0, 8'h00);
    chk({name, "_h2"}, {mips_en, send_signal}, 2'b01);
    halt = 1'b0;
  endtask

  task automatic do_load(input int n, input int gapmax);
    logic [31:0] w;
    tick(1'b1, CMD_LOAD);
    tick(1'b1, 8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, gapmax)) tick(1'b0, 8'h00);
        tick(1'b1, w[31 - 8*b -: 8]);
      end
      exp_wr.push_back({8'(i), w});
    end
    idle(2);
    chk($sformatf("load%0d_idle", n), state, IDLE);
  endtask

  task automatic cmp_writes(input string name);
    chk({name, "_wr_count"}, got_wr.size() - b_wr, exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (b_wr + i < got_wr.size())
        chk($sformatf("%s_wr%0d", name, i), got_wr[b_wr + i], exp_wr[i]);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       halt_in;
    logic [6:0] exp;   // {mips_en, mips_rst, cmd_error, busy, state}
  } vec_t;
  vec_t tbl[9];

  initial begin
    int e_en, e_send, e_rst, e_err, r, k, n;
    logic [7:0] ub;
    logic [7:0] seq3[10];

    tbl[0] = '{8'h73, 1'b0, {4'b1001, 3'(STEP)}};
    tbl[1] = '{8'h63, 1'b0, {4'b1001, 3'(RUN)}};
    tbl[2] = '{8'h63, 1'b1, {4'b1001, 3'(RUN)}};
    tbl[3] = '{8'h72, 1'b0, {4'b0101, 3'(RST)}};
    tbl[4] = '{8'h6C, 1'b0, {4'b0001, 3'(LOAD_CNT)}};
    tbl[5] = '{8'h41, 1'b0, {4'b0010, 3'(IDLE)}};
    tbl[6] = '{8'h00, 1'b0, {4'b0010, 3'(IDLE)}};
    tbl[7] = '{8'hFF, 1'b0, {4'b0010, 3'(IDLE)}};
    tbl[8] = '{8'h43, 1'b0, {4'b0010, 3'(IDLE)}};

    // First-cycle response of each command byte from IDLE.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      halt = tbl[i].halt_in;
      tick(1'b1, tbl[i].cmd);
      tick(1'b0, 8'h00);
      chk($sformatf("tbl%0d_cmd%02h", i, tbl[i].cmd),
          {mips_en, mips_rst, cmd_error, busy, state, send_signal}, {tbl[i].exp, 1'b0});
    end
    do_reset();

    // Step with a 10-cycle transmission.
    idle(3); snap();
    do_step("step");
    finish_frame(10, 0, "step");
    idle(3);
    chk("step_counts", {8'(en_cnt - b_en), 8'(send_cnt - b_send), 8'(err_cnt - b_err)},
        {8'd1, 8'd1, 8'd0});

    // Run with halt sampled on the 50th RUN cycle.
    snap();
    do_run(49, 1'b0, "run50");
    finish_frame(3, 0, "run50");
    idle(3);
    chk("run50_counts", {8'(en_cnt - b_en), 8'(send_cnt - b_send)}, {8'd50, 8'd1});

    // Back-to-back load of two words.
    snap();
    seq3 = '{8'h6C, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, seq3[i]);
      if (i == 6) chk("load2_w0", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 32'h20080005});
      if (i == 7) chk("load2_w0_pulse", imem_we, 1'b0);
    end
    tick(1'b0, 8'h00);
    chk("load2_w1", {imem_we, imem_addr, imem_wdata, state}, {1'b1, 8'd1, 32'h0000000C, 3'(IDLE)});
    idle(3);
    exp_wr.push_back({8'd0, 32'h20080005});
    exp_wr.push_back({8'd1, 32'h0000000C});
    cmp_writes("load2");

    // Zero-length load, then an unknown byte.
    snap();
    tick(1'b1, CMD_LOAD);
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    chk("load0_idle", {busy, state}, 4'd0);
    tick(1'b1, 8'h41);
    tick(1'b0, 8'h00);
    chk("err_pulse", {cmd_error, state}, {1'b1, 3'(IDLE)});
    tick(1'b0, 8'h00);
    chk("err_pulse_end", cmd_error, 1'b0);
    idle(2);
    cmp_writes("load0");

    // Processor reset, then a step with 's' bytes arriving during WAIT_TX.
    snap();
    tick(1'b1, CMD_RST);
    tick(1'b0, 8'h00);
    chk("rst_pulse", {mips_rst, state}, {1'b1, 3'(RST)});
    tick(1'b0, 8'h00);
    chk("rst_end", {mips_rst, state}, {1'b0, 3'(IDLE)});
    idle(3);
    chk("rst_counts", {8'(rst_cnt - b_rst), 8'(send_cnt - b_send)}, {8'd1, 8'd0});
    snap();
    do_step("step_junk");
    finish_frame(5, 1, "step_junk");
    idle(3);
    chk("step_junk_counts", {8'(en_cnt - b_en), 8'(send_cnt - b_send), 8'(err_cnt - b_err)},
        {8'd1, 8'd1, 8'd0});

    // Reset in the middle of the second word of a 3-word load.
    snap();
    tick(1'b1, CMD_LOAD);
    tick(1'b1, 8'd3);
    foreach (seq3[i]) seq3[i] = 8'h00;
    seq3[0] = 8'h11; seq3[1] = 8'h22; seq3[2] = 8'h33; seq3[3] = 8'h44;
    seq3[4] = 8'h55; seq3[5] = 8'h66;
    for (int i = 0; i < 6; i++) tick(1'b1, seq3[i]);
    tick(1'b0, 8'h00);
    chk("abort_mid_state", state, LOAD_WORD);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {mips_en, mips_rst, send_signal, imem_we, cmd_error, busy,
                          state, imem_addr, imem_wdata}, 64'd0);
    tick(1'b0, 8'h00);
    reset = 1'b0;
    idle(3);
    exp_wr.push_back({8'd0, 32'h11223344});
    cmp_writes("abort");
    b_en = en_cnt; b_send = send_cnt;
    do_step("abort_step");
    finish_frame(2, 0, "abort_step");
    idle(3);
    chk("abort_step_counts", {8'(en_cnt - b_en), 8'(send_cnt - b_send)}, {8'd1, 8'd1});

    // Randomized command stream against expected event totals.
    idle(3); snap();
    e_en = 0; e_send = 0; e_rst = 0; e_err = 0;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: begin
          do_step($sformatf("rnd%0d_step", it));
          finish_frame($urandom_range(1, 4), 2, $sformatf("rnd%0d_step", it));
          e_en++; e_send++;
        end
        1: begin
          k = $urandom_range(0, 6);
          do_run(k, 1'b1, $sformatf("rnd%0d_run", it));
          finish_frame($urandom_range(1, 4), 2, $sformatf("rnd%0d_run", it));
          e_en += k + 1; e_send++;
        end
        2: begin
          tick(1'b1, CMD_RST);
          tick(1'b0, 8'h00);
          e_rst++;
        end
        3: begin
          n = $urandom_range(0, 4);
          do_load(n, $urandom_range(0, 1));
        end
        default: begin
          do ub = 8'($urandom); while (is_known_cmd(ub));
          tick(1'b1, ub);
          e_err++;
        end
      endcase
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("rnd_en_cycles", en_cnt - b_en, e_en);
    chk("rnd_sends", send_cnt - b_send, e_send);
    chk("rnd_rsts", rst_cnt - b_rst, e_rst);
    chk("rnd_errors", err_cnt - b_err, e_err);
    cmp_writes("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
